// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: parametrised inter-stage pipeline register with a
// valid/ready handshake and a 2-entry skid buffer.
// Optional feature macro: STAGE_PERF_EN builds the saturating stall and
// bubble counters. Without it the counter ports are tied to zero.
module pipe_stage_buf #(
  parameter int              WIDTH     = 32,
  parameter int              NCH       = 5,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int              CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NCH*WIDTH-1:0] out_data,
  output logic [1:0]           occupancy,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     bubble_cnt
);

  localparam int D = NCH * WIDTH;
  localparam logic [D-1:0] RST_BUS = {NCH{RESET_VAL}};

  // The state value doubles as the entry count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [D-1:0] main_q, main_d;
  logic [D-1:0] skid_q, skid_d;
  logic         push, pop;

  // Handshake outputs decode only registered state, so a downstream stall
  // never reaches in_ready combinationally.
  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign occupancy = 2'(state_q);
  assign out_data  = main_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // State and data registers; reset discards every held entry at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= RST_BUS;
      skid_q  <= RST_BUS;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Next-state and data-load decisions; flush wins and empties the stage.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = RST_BUS;
      skid_d  = RST_BUS;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_d = in_data;
          end else if (push) begin
            state_d = TWO;
            skid_d  = in_data;
          end else if (pop) begin
            state_d = EMPTY;
            main_d  = RST_BUS;
          end
        end
        TWO: begin
          if (pop) begin
            state_d = ONE;
            main_d  = skid_q;
            skid_d  = RST_BUS;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = RST_BUS;
          skid_d  = RST_BUS;
        end
      endcase
    end
  end

`ifdef STAGE_PERF_EN
  logic [CNT_W-1:0] stall_q, bubble_q;

  // Saturating performance counters; only reset clears them, not flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}}))
        stall_q <= stall_q + CNT_W'(1);
      if (!out_valid && (bubble_q != {CNT_W{1'b1}}))
        bubble_q <= bubble_q + CNT_W'(1);
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: randomized self-checking bench for pipe_stage_buf,
// compared against a queue-based FIFO model of at most two entries.
module tb_pipe_stage_buf;

  localparam int WIDTH = 32;
  localparam int NCH   = 5;
  localparam int CNT_W = 4;
  localparam int D     = WIDTH * NCH;
  localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef STAGE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [D-1:0]     in_data = '0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [D-1:0]     out_data;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] bubble_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: queue of accepted beats plus counter values.
  logic [D-1:0] mq[$];
  int stall_m = 0;
  int bubble_m = 0;

  pipe_stage_buf #(
    .WIDTH(WIDTH), .NCH(NCH), .RESET_VAL('0), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .occupancy(occupancy),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Channel order: DMOut, PC, ALURes, Instr, HL from the low end.
  function automatic logic [D-1:0] beat(input logic [31:0] pc, input logic [31:0] instr);
    return {$urandom(), instr, $urandom(), pc, $urandom()};
  endfunction

  function automatic logic [D-1:0] exp_data();
    return (mq.size() > 0) ? mq[0] : '0;
  endfunction

  // {out_valid, in_ready, occupancy}
  function automatic logic [3:0] exp_status();
    return {mq.size() > 0, mq.size() < 2, 2'(mq.size())};
  endfunction

  function automatic logic [CNT_W-1:0] exp_stall();
    return PERF ? CNT_W'(stall_m) : '0;
  endfunction

  function automatic logic [CNT_W-1:0] exp_bubble();
    return PERF ? CNT_W'(bubble_m) : '0;
  endfunction

  // Advance one clock edge, updating the model from the pre-edge inputs.
  task automatic tick();
    bit push, pop;
    push = in_valid && (mq.size() < 2);
    pop  = (mq.size() > 0) && out_ready;
    if ((mq.size() > 0) && !out_ready && stall_m < CMAX) stall_m++;
    if ((mq.size() == 0) && bubble_m < CMAX) bubble_m++;
    if (flush) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(in_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    mq.delete();
    stall_m = 0;
    bubble_m = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({out_valid, in_ready, occupancy} !== 4'b0100 || out_data !== '0) begin
      n_bad++;
      $display("[TB] FAIL reset_hold: status=%b data=%h, want status=0100 data=0", {out_valid, in_ready, occupancy}, out_data);
    end
    do_reset();
    n_cmp++;
    if ({out_valid, in_ready, occupancy} !== 4'b0100 || out_data !== '0 || stall_cnt !== '0 || bubble_cnt !== '0) begin
      n_bad++;
      $display("[TB] FAIL reset_release: status=%b data=%h stall=%0d bubble=%0d, want 0100/0/0/0", {out_valid, in_ready, occupancy}, out_data, stall_cnt, bubble_cnt);
    end
  endtask

  task automatic test_single();
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = beat(32'h3000, 32'h1234);
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_data[WIDTH +: WIDTH] !== 32'h3000 || out_data !== exp_data()) begin
      n_bad++;
      $display("[TB] FAIL single_out: valid=%b pc=%h data=%h, want valid=1 pc=3000 data=%h", out_valid, out_data[WIDTH +: WIDTH], out_data, exp_data());
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== '0) begin
      n_bad++;
      $display("[TB] FAIL single_drain: valid=%b data=%h, want valid=0 data=0", out_valid, out_data);
    end
  endtask

  task automatic test_skid();
    logic [31:0] want_pc [3];
    want_pc = '{32'h11, 32'h22, 32'h0};
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = beat(32'h11, 32'h1);
    tick();
    in_data = beat(32'h22, 32'h2);
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== exp_data()) begin
      n_bad++;
      $display("[TB] FAIL skid_full: occ=%0d in_ready=%b data=%h, want occ=2 in_ready=0 data=%h", occupancy, in_ready, out_data, exp_data());
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (out_data[WIDTH +: WIDTH] !== want_pc[i] || {out_valid, in_ready, occupancy} !== exp_status()) begin
        n_bad++;
        $display("[TB] FAIL skid_drain[%0d]: pc=%h status=%b, want pc=%h status=%b", i, out_data[WIDTH +: WIDTH], {out_valid, in_ready, occupancy}, want_pc[i], exp_status());
      end
      tick();
    end
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_data = beat($urandom(), 32'(i));
      tick();
      n_cmp++;
      if (out_data[3*WIDTH +: WIDTH] !== 32'(i) || occupancy !== 2'd1 || out_data !== exp_data()) begin
        n_bad++;
        $display("[TB] FAIL stream[%0d]: instr=%0d occ=%0d, want instr=%0d occ=1", i, out_data[3*WIDTH +: WIDTH], occupancy, i);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    logic [D-1:0] marker;
    bit seen;
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_data = beat(32'h40 + 32'(i), 32'h8 + 32'(i));
      tick();
    end
    marker = beat(32'hDEAD, 32'hBEEF);
    in_data = marker;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    n_cmp++;
    if (occupancy !== 2'd0 || out_data !== '0 || out_valid !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL flush_full: occ=%0d valid=%b data=%h, want occ=0 valid=0 data=0", occupancy, out_valid, out_data);
    end
    // Flush at occupancy 1 with in_ready=1: the push is still dropped.
    in_valid = 1'b1;
    in_data = beat(32'h50, 32'h9);
    tick();
    in_data = marker;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid || out_data == marker) seen = 1'b1;
      tick();
    end
    n_cmp++;
    if (seen !== 1'b0 || occupancy !== 2'd0) begin
      n_bad++;
      $display("[TB] FAIL flush_drop: beat_seen=%b occ=%0d, want beat_seen=0 occ=0", seen, occupancy);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_data = beat($urandom(), $urandom());
      tick();
    end
    in_valid = 1'b0;
    n_cmp++;
    if (occupancy !== 2'd2) begin
      n_bad++;
      $display("[TB] FAIL areset_fill: occ=%0d, want 2", occupancy);
    end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({out_valid, in_ready, occupancy} !== 4'b0100 || out_data !== '0 || stall_cnt !== '0 || bubble_cnt !== '0) begin
      n_bad++;
      $display("[TB] FAIL areset_immediate: status=%b data=%h stall=%0d bubble=%0d, want 0100/0/0/0", {out_valid, in_ready, occupancy}, out_data, stall_cnt, bubble_cnt);
    end
    mq.delete();
    stall_m = 0;
    bubble_m = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_perf();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = beat(32'h60, 32'h6);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    n_cmp++;
    if (stall_cnt !== (PERF ? CNT_W'(15) : CNT_W'(0)) || bubble_cnt !== exp_bubble()) begin
      n_bad++;
      $display("[TB] FAIL perf_saturate: stall=%0d bubble=%0d, want stall=%0d bubble=%0d", stall_cnt, bubble_cnt, PERF ? 15 : 0, exp_bubble());
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_cmp++;
    if (stall_cnt !== (PERF ? CNT_W'(15) : CNT_W'(0)) || bubble_cnt !== (PERF ? CNT_W'(1) : CNT_W'(0))) begin
      n_bad++;
      $display("[TB] FAIL perf_flush: stall=%0d bubble=%0d, want stall=%0d bubble=%0d", stall_cnt, bubble_cnt, PERF ? 15 : 0, PERF ? 1 : 0);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_data   = beat($urandom(), $urandom());
      tick();
      n_cmp++;
      if (out_data !== exp_data() || {out_valid, in_ready, occupancy} !== exp_status() ||
          stall_cnt !== exp_stall() || bubble_cnt !== exp_bubble()) begin
        n_bad++;
        $display("[TB] FAIL random[%0d]: status=%b data=%h stall=%0d bubble=%0d, want status=%b data=%h stall=%0d bubble=%0d",
                 i, {out_valid, in_ready, occupancy}, out_data, stall_cnt, bubble_cnt,
                 exp_status(), exp_data(), exp_stall(), exp_bubble());
      end
    end
    in_valid = 1'b0;
    flush = 1'b0;
  endtask

  // Run every scenario in sequence, then report.
  initial begin
    test_reset();
    test_single();
    test_skid();
    test_stream();
    test_flush();
    test_async_reset();
    test_perf();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
